// File: rtl/led_sched_pkg.sv
// led_sched_pkg: shared state encoding, default timing and priority pick for the LED scheduler.
// Revision 1.0
`default_nettype none

package led_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  localparam int TICK_DIV_DEF = 16000;
  localparam int ON_MS_DEF    = 200;
  localparam int OFF_MS_DEF   = 200;
  localparam int GAP_MS_DEF   = 1000;

  localparam int MAX_REQ = 32;

  // Isolates the lowest set bit; callers narrow the result to their requester count.
  function automatic logic [MAX_REQ-1:0] pick_lowest(input logic [MAX_REQ-1:0] req);
    return req & (~req + MAX_REQ'(1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// tick_gen: prescaler emitting a one-cycle tick every TICK_DIV cycles, restartable by clr_i.
// Revision 1.0
`default_nettype none

module tick_gen
  import led_sched_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_blink_scheduler.sv
// led_blink_scheduler: fixed-priority arbiter playing per-client blink codes on one LED, heartbeat when idle.
// Revision 1.0
`default_nettype none

module led_blink_scheduler
  import led_sched_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int N_REQ    = 4,
  parameter int CODE_W   = 4,
  parameter int ON_MS    = ON_MS_DEF,
  parameter int OFF_MS   = OFF_MS_DEF,
  parameter int GAP_MS   = GAP_MS_DEF,
  parameter int HB_BIT   = 23
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [N_REQ-1:0]          REQ,
  input  logic [N_REQ*CODE_W-1:0]   CODE,
  output logic [N_REQ-1:0]          GRANT,
  output logic [N_REQ-1:0]          DONE,
  output logic                      BUSY,
  output logic                      LED
);

  localparam int MAX_OO = (ON_MS > OFF_MS) ? ON_MS : OFF_MS;
  localparam int MAX_MS = (MAX_OO > GAP_MS) ? MAX_OO : GAP_MS;
  localparam int MS_W   = (MAX_MS > 1) ? $clog2(MAX_MS) : 1;

  state_e            state_q, state_d;
  logic [31:0]       hb_q, hb_d;
  logic [MS_W-1:0]   ms_q, ms_d, w_last;
  logic [CODE_W-1:0] blink_q, blink_d, w_code;
  logic [N_REQ-1:0]  grant_q, grant_d, done_q, done_d, w_pick;
  logic              led_q, led_d;
  logic              w_tick, w_clr, w_expire, w_req_any;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .clr_i  (w_clr),
    .tick_o (w_tick)
  );

  assign w_req_any = |REQ;
  assign w_pick    = N_REQ'(pick_lowest(MAX_REQ'(REQ)));

  always_comb begin
    w_code = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick[i]) begin
        w_code = CODE[i*CODE_W +: CODE_W];
      end
    end
  end

  always_comb begin
    case (state_q)
      ST_ON:   w_last = MS_W'(ON_MS - 1);
      ST_OFF:  w_last = MS_W'(OFF_MS - 1);
      ST_GAP:  w_last = MS_W'(GAP_MS - 1);
      default: w_last = '0;
    endcase
  end

  assign w_expire = w_tick && (ms_q == w_last);
  // Every state change restarts both the prescaler and the ms timer.
  assign w_clr    = (state_d != state_q);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (w_req_any) state_d = (w_code != '0) ? ST_ON : ST_GAP;
      ST_ON:   if (w_expire) state_d = ST_OFF;
      ST_OFF:  if (w_expire) state_d = (blink_q == CODE_W'(1)) ? ST_GAP : ST_ON;
      ST_GAP:  if (w_expire) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_d = grant_q;
    done_d  = '0;
    blink_d = blink_q;
    hb_d    = hb_q + 32'd1;
    ms_d    = w_tick ? (ms_q + MS_W'(1)) : ms_q;
    if (w_clr) begin
      ms_d = '0;
    end
    case (state_q)
      ST_IDLE: begin
        if (w_req_any) begin
          grant_d = w_pick;
          blink_d = w_code;
        end
      end
      ST_OFF: if (w_expire) blink_d = blink_q - CODE_W'(1);
      ST_GAP: begin
        if (w_expire) begin
          grant_d = '0;
          done_d  = grant_q;
        end
      end
      default: ;
    endcase
    // LED is registered from next-state so it tracks the state it is shown in.
    led_d = (state_d == ST_IDLE) ? hb_d[HB_BIT] : (state_d == ST_ON);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      hb_q    <= '0;
      ms_q    <= '0;
      blink_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      led_q   <= 1'b0;
    end else begin
      hb_q    <= hb_d;
      ms_q    <= ms_d;
      blink_q <= blink_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      led_q   <= led_d;
    end
  end

  assign GRANT = grant_q;
  assign DONE  = done_q;
  assign BUSY  = (state_q != ST_IDLE);
  assign LED   = led_q;

endmodule

`default_nettype wire

// File: tb/tb_led_blink_scheduler.sv
// tb_led_blink_scheduler: table vectors, corner sequences and random traffic against a play-length model.
// Revision 1.0
`default_nettype none

module tb_led_blink_scheduler;

  localparam int TD   = 4;
  localparam int ONT  = 2;
  localparam int OFFT = 2;
  localparam int GAPT = 3;
  localparam int PER  = (ONT + OFFT) * TD;
  localparam int ONC  = ONT * TD;
  localparam int GAPC = GAPT * TD;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [3:0]  REQ = 4'b0;
  logic [15:0] CODE = 16'h0;
  logic [3:0]  GRANT, DONE;
  logic        BUSY, LED;

  int n_vec = 0;
  int n_err = 0;

  led_blink_scheduler #(
    .TICK_DIV (TD),
    .N_REQ    (4),
    .CODE_W   (4),
    .ON_MS    (ONT),
    .OFF_MS   (OFFT),
    .GAP_MS   (GAPT),
    .HB_BIT   (3)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .REQ   (REQ),
    .CODE  (CODE),
    .GRANT (GRANT),
    .DONE  (DONE),
    .BUSY  (BUSY),
    .LED   (LED)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: a play is a grant time plus a length; outputs follow from elapsed cycles.
  initial begin : model
    logic [31:0] hb;
    bit          act;
    int          cli, n, k, len;
    logic [3:0]  dn, eg, r;
    logic [15:0] c;
    logic        eled;
    hb = 0; act = 0; cli = 0; n = 0; k = 0; len = 0; dn = 0;
    forever begin
      @(posedge CLK);
      r = REQ;
      c = CODE;
      if (!RST_N) begin
        hb = 0; act = 0; dn = 0;
      end else begin
        hb = hb + 1;
        dn = 0;
        if (act) begin
          k++;
          if (k == len) begin
            act = 0;
            dn  = 4'(1 << cli);
          end
        end else if (r != 0) begin
          cli = 0;
          while (!r[cli]) cli++;
          n   = int'(c[cli*4 +: 4]);
          k   = 0;
          len = n * PER + GAPC;
          act = 1;
        end
      end
      eg   = act ? 4'(1 << cli) : 4'b0;
      eled = act ? ((k < n * PER) && ((k % PER) < ONC)) : hb[3];
      @(negedge CLK);
      chk("outputs{GRANT,DONE,BUSY,LED}", {22'b0, GRANT, DONE, BUSY, LED},
          {22'b0, eg, dn, act, eled});
    end
  end

  task automatic wait_grant();
    int t = 0;
    while (GRANT == 0 && t < 8) begin
      @(negedge CLK);
      t++;
    end
    chk("grant_arrived", {31'b0, GRANT != 0}, 32'd1);
  endtask

  task automatic measure(input bit mid, output int len, output int pulses);
    logic pl = 1'b0;
    len = 0;
    pulses = 0;
    while (GRANT != 0 && len < 400) begin
      if (LED && !pl) pulses++;
      pl = LED;
      len++;
      if (mid && len == 3) begin
        REQ  = 4'b0;
        CODE = 16'h9999;
      end
      @(negedge CLK);
    end
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [15:0] code;
    logic [3:0]  g;
    int          pulses;
    int          len;
  } vec_t;

  vec_t tbl[5];

  initial begin : stim
    int len, pul, tog;
    logic prev;
    tbl[0] = '{4'b0100, 16'h0300, 4'b0100, 3, 60};
    tbl[1] = '{4'b0001, 16'h5550, 4'b0001, 0, 12};
    tbl[2] = '{4'b1000, 16'hF000, 4'b1000, 15, 252};
    tbl[3] = '{4'b1010, 16'h5010, 4'b0010, 1, 28};
    tbl[4] = '{4'b1111, 16'h1232, 4'b0001, 2, 44};

    // Reset, then idle heartbeat
    repeat (3) begin
      @(negedge CLK);
      chk("reset_outputs", {28'b0, GRANT, DONE, BUSY, LED} >> 0, 32'd0);
    end
    RST_N = 1'b1;
    @(negedge CLK);
    prev = LED;
    tog = 0;
    repeat (63) begin
      @(negedge CLK);
      if (LED != prev) tog++;
      prev = LED;
    end
    chk("idle_led_toggles", tog, 32'd8);

    for (int i = 0; i < 5; i++) begin
      REQ  = tbl[i].req;
      CODE = tbl[i].code;
      wait_grant();
      chk($sformatf("vec%0d_grant", i), {28'b0, GRANT}, {28'b0, tbl[i].g});
      measure(1'b0, len, pul);
      chk($sformatf("vec%0d_len", i), len, tbl[i].len);
      chk($sformatf("vec%0d_pulses", i), pul, tbl[i].pulses);
      chk($sformatf("vec%0d_done", i), {28'b0, DONE}, {28'b0, tbl[i].g});
      REQ = 4'b0;
      repeat (2) @(negedge CLK);
    end

    // Two simultaneous requests: priority then back-to-back regrant
    REQ  = 4'b1010;
    CODE = 16'h2010;
    wait_grant();
    chk("pri_first_grant", {28'b0, GRANT}, 32'b0010);
    measure(1'b0, len, pul);
    chk("pri_first_done", {28'b0, DONE}, 32'b0010);
    REQ = 4'b1000;
    @(negedge CLK);
    chk("pri_second_grant", {28'b0, GRANT}, 32'b1000);
    measure(1'b0, len, pul);
    chk("pri_second_len", len, 32'd44);
    chk("pri_second_done", {28'b0, DONE}, 32'b1000);
    REQ = 4'b0;
    repeat (2) @(negedge CLK);

    // Mid-play REQ drop and CODE change are ignored
    REQ  = 4'b0001;
    CODE = 16'h0002;
    wait_grant();
    measure(1'b1, len, pul);
    chk("midplay_pulses", pul, 32'd2);
    chk("midplay_len", len, 32'd44);
    chk("midplay_done", {28'b0, DONE}, 32'b0001);
    repeat (2) @(negedge CLK);

    // Reset during ON abandons the code; held REQ replays it in full
    REQ  = 4'b0001;
    CODE = 16'h0002;
    wait_grant();
    repeat (3) @(negedge CLK);
    chk("rstplay_led_on", {31'b0, LED}, 32'd1);
    RST_N = 1'b0;
    @(negedge CLK);
    chk("rstplay_outputs", {22'b0, GRANT, DONE, BUSY, LED}, 32'd0);
    @(negedge CLK);
    chk("rstplay_no_done", {28'b0, DONE}, 32'd0);
    RST_N = 1'b1;
    wait_grant();
    chk("rstplay_regrant", {28'b0, GRANT}, 32'b0001);
    measure(1'b0, len, pul);
    chk("rstplay_len", len, 32'd44);
    chk("rstplay_pulses", pul, 32'd2);
    chk("rstplay_done", {28'b0, DONE}, 32'b0001);
    REQ = 4'b0;
    repeat (2) @(negedge CLK);

    // Random traffic, checked cycle by cycle by the model
    for (int cy = 0; cy < 2500; cy++) begin
      if ($urandom_range(7) == 0) REQ = 4'($urandom);
      if ($urandom_range(7) == 0) CODE = 16'($urandom) & 16'h3333;
      RST_N = ($urandom_range(299) != 0);
      @(negedge CLK);
    end
    RST_N = 1'b1;
    REQ = 4'b0;
    repeat (80) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
